// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: sequencer states, the branch
// and jump opcodes, the sequential PC step and the J/JAL target helper.
package mips_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } state_t;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   localparam logic [31:0] PC_STEP = 32'd4;

   // J/JAL target: keep the upper nibble of PC+4, word-align the index.
   function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                              input logic [25:0] jidx);
      return {pcPlus4[31:28], jidx, 2'b00};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on i_inc and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count events, clearing on reset and refusing to wrap past the top value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_sequencer.sv
// Next-PC controller: owns the fetch PC, feeds the external branch-target
// adder, picks PC+4 / branch target / jump target, holds fetch while a branch
// waits for forwardable operands, and flushes IF/ID on every redirect.
module branch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_id_beq,
   input  logic             i_id_bne,
   input  logic             i_id_jump,
   input  logic             i_id_eq,
   input  logic             i_id_dep,
   input  logic [31:0]      i_id_pc_plus4,
   input  logic [31:0]      i_id_imm_ext,
   input  logic [25:0]      i_id_jidx,
   input  logic [31:0]      i_tgt_sum,
   output logic [31:0]      o_tgt_in,
   output logic [31:0]      o_tgt_pc,
   output logic [31:0]      o_pc,
   output logic             o_flush_ifid,
   output logic             o_stall_req,
   output logic [CNT_W-1:0] o_taken_cnt,
   output logic [CNT_W-1:0] o_wait_cnt
);

   import mips_pkg::*;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic        w_flush;
   logic        w_stallReq;
   logic        w_takenInc;
   logic        w_waitInc;
   logic        w_isBranch;
   logic        w_branchTaken;
   logic [31:0] w_jumpTarget;
   logic [31:0] w_immShift;

   assign w_isBranch    = i_id_beq | i_id_bne;
   assign w_branchTaken = (i_id_beq & i_id_eq) | (i_id_bne & ~i_id_eq);
   assign w_jumpTarget  = jumpTarget(i_id_pc_plus4, i_id_jidx);
   assign w_immShift    = i_id_imm_ext << 2;

   // State and PC register; reset parks the sequencer in RUN at RESET_PC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_stateNext;
         r_pc    <= w_pcNext;
      end
   end

   // Enter BR_WAIT on a branch with unforwardable operands, leave once they arrive.
   always_comb begin
      w_stateNext = r_state;
      if (!i_stall) begin
         unique case (r_state)
            RUN: begin
               if (!i_id_jump && w_isBranch && i_id_dep) begin
                  w_stateNext = BR_WAIT;
               end
            end
            BR_WAIT: begin
               if (!i_id_dep) begin
                  w_stateNext = RUN;
               end
            end
            default: w_stateNext = RUN;
         endcase
      end
   end

   // Choose the next PC and raise flush, hold and counter pulses; all quiet in reset or stall.
   always_comb begin
      w_pcNext   = r_pc;
      w_flush    = 1'b0;
      w_stallReq = 1'b0;
      w_takenInc = 1'b0;
      w_waitInc  = 1'b0;
      if (!i_rst && !i_stall) begin
         unique case (r_state)
            RUN: begin
               if (i_id_jump) begin
                  w_pcNext   = w_jumpTarget;
                  w_flush    = 1'b1;
                  w_takenInc = 1'b1;
               end else if (w_isBranch && i_id_dep) begin
                  w_stallReq = 1'b1;
               end else if (w_branchTaken) begin
                  w_pcNext   = i_tgt_sum;
                  w_flush    = 1'b1;
                  w_takenInc = 1'b1;
               end else begin
                  w_pcNext = r_pc + PC_STEP;
               end
            end
            BR_WAIT: begin
               if (i_id_dep) begin
                  w_stallReq = 1'b1;
                  w_waitInc  = 1'b1;
               end else if (w_branchTaken) begin
                  w_pcNext   = i_tgt_sum;
                  w_flush    = 1'b1;
                  w_takenInc = 1'b1;
               end else begin
                  w_pcNext = r_pc + PC_STEP;
               end
            end
            default: w_pcNext = r_pc;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_takenCnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_takenInc),
      .o_cnt (o_taken_cnt)
   );

   sat_counter #(.W(CNT_W)) u_waitCnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_waitInc),
      .o_cnt (o_wait_cnt)
   );

   assign o_tgt_in     = i_rst ? 32'h0 : w_immShift;
   assign o_tgt_pc     = i_rst ? 32'h0 : i_id_pc_plus4;
   assign o_pc         = r_pc;
   assign o_flush_ifid = w_flush;
   assign o_stall_req  = w_stallReq;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: each directed cycle pushes its
// hand-computed expectation, and a negedge monitor pops and compares.
module tb_branch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          CNT_W    = 2;

   logic             clock;
   logic             reset;
   logic             stall;
   logic             idBeq;
   logic             idBne;
   logic             idJump;
   logic             idEq;
   logic             idDep;
   logic [31:0]      idPcPlus4;
   logic [31:0]      idImmExt;
   logic [25:0]      idJidx;
   logic [31:0]      tgtSum;
   logic [31:0]      tgtIn;
   logic [31:0]      tgtPc;
   logic [31:0]      pc;
   logic             flushIfid;
   logic             stallReq;
   logic [CNT_W-1:0] takenCnt;
   logic [CNT_W-1:0] waitCnt;

   typedef struct {
      logic [31:0]      pc;
      logic             flush;
      logic             stallReq;
      logic [CNT_W-1:0] takenCnt;
      logic [CNT_W-1:0] waitCnt;
      logic [31:0]      tgtIn;
      logic [31:0]      tgtPc;
   } expect_t;

   expect_t scoreboard[$];
   int      errorCount = 0;
   int      checkCount = 0;

   branch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .i_clk         (clock),
      .i_rst         (reset),
      .i_stall       (stall),
      .i_id_beq      (idBeq),
      .i_id_bne      (idBne),
      .i_id_jump     (idJump),
      .i_id_eq       (idEq),
      .i_id_dep      (idDep),
      .i_id_pc_plus4 (idPcPlus4),
      .i_id_imm_ext  (idImmExt),
      .i_id_jidx     (idJidx),
      .i_tgt_sum     (tgtSum),
      .o_tgt_in      (tgtIn),
      .o_tgt_pc      (tgtPc),
      .o_pc          (pc),
      .o_flush_ifid  (flushIfid),
      .o_stall_req   (stallReq),
      .o_taken_cnt   (takenCnt),
      .o_wait_cnt    (waitCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one observed value against its expectation and log any miss.
   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Check every DUT output against one scoreboard entry.
   task automatic checkOutput(input expect_t e);
      checkField("pc",         pc,        e.pc);
      checkField("flush_ifid", flushIfid, e.flush);
      checkField("stall_req",  stallReq,  e.stallReq);
      checkField("taken_cnt",  takenCnt,  e.takenCnt);
      checkField("wait_cnt",   waitCnt,   e.waitCnt);
      checkField("tgt_in",     tgtIn,     e.tgtIn);
      checkField("tgt_pc",     tgtPc,     e.tgtPc);
   endtask

   // Monitor: mid-cycle, pop the pending expectation and compare.
   always @(negedge clock) begin : monitor
      expect_t e;
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput(e);
      end
   end

   // Advance to just after the next rising edge and return inputs to idle.
   task automatic nextCycle();
      @(posedge clock);
      #1;
      reset     = 1'b0;
      stall     = 1'b0;
      idBeq     = 1'b0;
      idBne     = 1'b0;
      idJump    = 1'b0;
      idEq      = 1'b0;
      idDep     = 1'b0;
      idPcPlus4 = 32'h0;
      idImmExt  = 32'h0;
      idJidx    = 26'h0;
      tgtSum    = 32'h0;
   endtask

   // Queue the expected response for the inputs now driven this cycle.
   task automatic applyStimulus(input logic [31:0] expPc, input logic expFlush,
                                input logic expStallReq, input logic [CNT_W-1:0] expTaken,
                                input logic [CNT_W-1:0] expWait);
      expect_t e;
      e.pc       = expPc;
      e.flush    = expFlush;
      e.stallReq = expStallReq;
      e.takenCnt = expTaken;
      e.waitCnt  = expWait;
      e.tgtIn    = reset ? 32'h0 : (idImmExt << 2);
      e.tgtPc    = reset ? 32'h0 : idPcPlus4;
      scoreboard.push_back(e);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed vectors, one cycle per applyStimulus call.
   initial begin
      reset = 1'b1; stall = 1'b0; idBeq = 1'b0; idBne = 1'b0; idJump = 1'b0;
      idEq = 1'b0; idDep = 1'b0; idPcPlus4 = 32'h0; idImmExt = 32'h0;
      idJidx = 26'h0; tgtSum = 32'h0;

      // reset, then free-running PC+4
      nextCycle(); reset = 1'b1; idImmExt = 32'h1; idPcPlus4 = 32'h55;
      applyStimulus(32'h0040_0000, 1'b0, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0040_0000, 1'b0, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0040_0004, 1'b0, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0040_0008, 1'b0, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0040_000C, 1'b0, 1'b0, 2'd0, 2'd0);

      // taken BEQ with negative offset
      nextCycle(); idBeq = 1'b1; idEq = 1'b1; idPcPlus4 = 32'h100; idImmExt = 32'hFFFF_FFFE; tgtSum = 32'hF8;
      applyStimulus(32'h0040_0010, 1'b1, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0000_00F8, 1'b0, 1'b0, 2'd1, 2'd0);

      // not-taken BNE
      nextCycle(); idBne = 1'b1; idEq = 1'b1; idPcPlus4 = 32'hFC; idImmExt = 32'h10; tgtSum = 32'h999;
      applyStimulus(32'h0000_00FC, 1'b0, 1'b0, 2'd1, 2'd0);
      nextCycle(); applyStimulus(32'h0000_0100, 1'b0, 1'b0, 2'd1, 2'd0);

      // dependent BEQ: wait, freeze by stall inside BR_WAIT, wait, resolve taken
      nextCycle(); idBeq = 1'b1; idDep = 1'b1; tgtSum = 32'h2000;
      applyStimulus(32'h0000_0104, 1'b0, 1'b1, 2'd1, 2'd0);
      nextCycle(); stall = 1'b1; idBeq = 1'b1; idDep = 1'b1; tgtSum = 32'h2000;
      applyStimulus(32'h0000_0104, 1'b0, 1'b0, 2'd1, 2'd0);
      nextCycle(); idBeq = 1'b1; idDep = 1'b1; tgtSum = 32'h2000;
      applyStimulus(32'h0000_0104, 1'b0, 1'b1, 2'd1, 2'd0);
      nextCycle(); idBeq = 1'b1; idEq = 1'b1; tgtSum = 32'h2000;
      applyStimulus(32'h0000_0104, 1'b1, 1'b0, 2'd1, 2'd1);
      nextCycle(); applyStimulus(32'h0000_2000, 1'b0, 1'b0, 2'd2, 2'd1);

      // jump beats a simultaneous taken BEQ
      nextCycle(); idJump = 1'b1; idBeq = 1'b1; idEq = 1'b1; idJidx = 26'h10; idPcPlus4 = 32'h3000_0004; tgtSum = 32'h5555;
      applyStimulus(32'h0000_2004, 1'b1, 1'b0, 2'd2, 2'd1);
      nextCycle(); applyStimulus(32'h3000_0040, 1'b0, 1'b0, 2'd3, 2'd1);

      // jump held by stall, then released (taken count already saturated)
      nextCycle(); stall = 1'b1; idJump = 1'b1; idJidx = 26'h20; idPcPlus4 = 32'h3000_0044;
      applyStimulus(32'h3000_0044, 1'b0, 1'b0, 2'd3, 2'd1);
      nextCycle(); stall = 1'b1; idJump = 1'b1; idJidx = 26'h20; idPcPlus4 = 32'h3000_0044;
      applyStimulus(32'h3000_0044, 1'b0, 1'b0, 2'd3, 2'd1);
      nextCycle(); idJump = 1'b1; idJidx = 26'h20; idPcPlus4 = 32'h3000_0044;
      applyStimulus(32'h3000_0044, 1'b1, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'h3000_0080, 1'b0, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'h3000_0084, 1'b0, 1'b0, 2'd3, 2'd1);

      // jump to zero; wait, the idle above advanced pc: jump issued here
      nextCycle(); idJump = 1'b1; idJidx = 26'h0; idPcPlus4 = 32'h0;
      applyStimulus(32'h3000_0088, 1'b1, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'h0000_0000, 1'b0, 1'b0, 2'd3, 2'd1);

      // branch to the top word, then sequential wrap to 0
      nextCycle(); idBeq = 1'b1; idEq = 1'b1; tgtSum = 32'hFFFF_FFFC;
      applyStimulus(32'h0000_0004, 1'b1, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'h0000_0000, 1'b0, 1'b0, 2'd3, 2'd1);
      nextCycle(); applyStimulus(32'h0000_0004, 1'b0, 1'b0, 2'd3, 2'd1);

      // reset while in BR_WAIT
      nextCycle(); idBne = 1'b1; idDep = 1'b1;
      applyStimulus(32'h0000_0008, 1'b0, 1'b1, 2'd3, 2'd1);
      nextCycle(); idBne = 1'b1; idDep = 1'b1;
      applyStimulus(32'h0000_0008, 1'b0, 1'b1, 2'd3, 2'd1);
      nextCycle(); reset = 1'b1; idBne = 1'b1; idDep = 1'b1; idImmExt = 32'h4;
      applyStimulus(32'h0000_0008, 1'b0, 1'b0, 2'd3, 2'd2);
      nextCycle(); applyStimulus(32'h0040_0000, 1'b0, 1'b0, 2'd0, 2'd0);

      // back in RUN: a dependent BNE must start a fresh wait
      nextCycle(); idBne = 1'b1; idDep = 1'b1;
      applyStimulus(32'h0040_0004, 1'b0, 1'b1, 2'd0, 2'd0);
      nextCycle(); idBne = 1'b1; tgtSum = 32'h40;
      applyStimulus(32'h0040_0004, 1'b1, 1'b0, 2'd0, 2'd0);
      nextCycle(); applyStimulus(32'h0000_0040, 1'b0, 1'b0, 2'd1, 2'd0);

      // let the monitor drain the queue
      @(posedge clock);
      @(posedge clock);
      checkCount++;
      if (scoreboard.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL drain: got %0d entries left expected 0", scoreboard.size());
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Next-PC controller for the pipelined MIPS core. It owns the PC register and drives the operands of the branch-target adder (sum = in + pc). It selects among PC+4, the branch target and the jump target, and holds the fetch stage while a branch waits for its operands. It also produces the IF/ID flush on every redirect and keeps saturating event counters for taken branches and branch-wait cycles.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the event counters
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit load-use stall; freezes this block
- id_beq  in  1  BEQ decoded in ID
- id_bne  in  1  BNE decoded in ID
- id_jump  in  1  J/JAL decoded in ID
- id_eq  in  1  ID register comparator: rs == rt
- id_dep  in  1  a branch operand is not yet forwardable (EX/MEM producer)
- id_pc_plus4  in  32  PC+4 of the instruction in ID
- id_imm_ext  in  32  sign-extended 16-bit offset
- id_jidx  in  26  jump index field
- tgt_sum  in  32  result from the branch-target adder
- tgt_in  out  32  adder operand: id_imm_ext << 2
- tgt_pc  out  32  adder operand: id_pc_plus4
- pc  out  32  registered fetch PC
- flush_ifid  out  1  combinational; clear IF/ID at this edge
- stall_req  out  1  combinational; hold PC and IF/ID (branch wait)
- taken_cnt  out  CNT_W  taken branches and jumps, saturating
- wait_cnt  out  CNT_W  cycles spent in BR_WAIT, saturating

## Operation
- States: RUN, BR_WAIT. Reset sets state to RUN, pc to RESET_PC and both counters to 0.
- Combinational outputs are 0 while rst is high.
- Jump target: {id_pc_plus4[31:28], id_jidx, 2'b00}.
- Branch target: tgt_sum.
- tgt_in and tgt_pc are driven continuously from the ID inputs.
- A branch is taken when (id_beq & id_eq) | (id_bne & ~id_eq).
- Sequential increment is pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Priority in RUN, evaluated each cycle, first match wins:
  - stall: hold pc, state and counters; flush_ifid=0, stall_req=0.
  - id_jump: pc <= jump target; flush_ifid=1; taken_cnt++. id_jump beats a simultaneous branch flag.
  - (id_beq|id_bne) & id_dep: hold pc; stall_req=1; go to BR_WAIT.
  - branch taken: pc <= tgt_sum; flush_ifid=1; taken_cnt++.
  - otherwise, including a not-taken branch: pc <= pc + 4.
- BR_WAIT, first match wins:
  - stall: freeze exactly as in RUN.
  - id_dep=1: hold pc; stall_req=1; wait_cnt++.
  - id_dep=0: resolve the branch using the RUN rules for a taken or not-taken branch, then return to RUN. stall_req=0 in this cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset during BR_WAIT returns to RUN with pc = RESET_PC. No flush is issued.

## Timing
- Branch and jump resolution happen in ID.
- Redirect: flush_ifid is high in the decision cycle. pc shows the target after that same rising edge, so the penalty is one bubble.
- A dependent branch costs one bubble plus N BR_WAIT cycles, where N is the number of cycles id_dep stays high after the first.
- stall_req and flush_ifid are never high in the same cycle.
- pc changes only on rising edges. It has no combinational path from inputs.

## Structure
- Shared package (mips_pkg):
  - state enum {RUN, BR_WAIT}
  - opcode constants for BEQ, BNE, J, JAL
  - localparam PC_STEP = 4
- The adder stays an external instance. This block only sequences it.
- A single sub-module, sat_counter (parameter W, inputs inc and rst, output cnt), is instantiated twice.

## Test plan
- Reset with RESET_PC=32'h0040_0000, then 3 free cycles -> pc sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; flush_ifid=0; counters 0.
- BEQ, id_eq=1, id_pc_plus4=0x100, id_imm_ext=0xFFFF_FFFE -> tgt_in=0xFFFF_FFF8; tgt_sum=0xF8 drives pc=0xF8 next cycle; flush_ifid high for 1 cycle; taken_cnt=1.
- BNE with id_eq=1 -> not taken; pc+4; flush_ifid=0.
- BEQ with id_dep high for 2 cycles, then id_eq=1 -> stall_req high for 2 cycles, then flush_ifid for 1 cycle; wait_cnt=1; pc=tgt_sum.
- id_jump and id_beq together with id_jidx=0x0000010 and id_pc_plus4=0x3000_0004 -> pc=0x3000_0040; stall held high during a jump -> pc unchanged and no flush until stall drops.
- pc=0xFFFF_FFFC sequential -> pc=0. CNT_W=2 with 5 taken jumps -> taken_cnt=3. rst asserted in BR_WAIT -> state RUN, pc=RESET_PC, stall_req=0.
